// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester arbiter for the shared synchronous-read memory port
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed m0-first priority.
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_wr,
  input  logic          m0_byt,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_wr,
  input  logic          m1_byt,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr,
  output logic          mem_byt,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state;
  state_t        state_nx;
  logic          grant;
  logic          gsel;
  logic          cur_wr;
  logic          ack_w;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;

`ifndef MEM_ARB_FIXED_PRIO_EN
  logic          last;
`endif

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    gsel     = owner;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant    = 1'b1;
          state_nx = ISSUE;
`ifdef MEM_ARB_FIXED_PRIO_EN
          gsel     = ~m0_req;
`else
          gsel     = (m0_req && m1_req) ? ~last : m1_req;
`endif
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        state_nx = IDLE;
        // The owner's own req belongs to the access being acked, so only the other side may chain.
`ifdef MEM_ARB_FIXED_PRIO_EN
        if (owner && m0_req) begin
          grant    = 1'b1;
          gsel     = 1'b0;
          state_nx = ISSUE;
        end
`else
        if (owner ? m0_req : m1_req) begin
          grant    = 1'b1;
          gsel     = ~owner;
          state_nx = ISSUE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_byt   <= 1'b0;
      mem_wdata <= '0;
      owner     <= 1'b0;
      cur_wr    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state  <= state_nx;
      mem_wr <= 1'b0;
      if (grant) begin
        owner     <= gsel;
        mem_addr  <= gsel ? m1_addr  : m0_addr;
        mem_wr    <= gsel ? m1_wr    : m0_wr;
        mem_byt   <= gsel ? m1_byt   : m0_byt;
        mem_wdata <= gsel ? m1_wdata : m0_wdata;
        cur_wr    <= gsel ? m1_wr    : m0_wr;
      end
      if (state == WAIT && !cur_wr) begin
        if (owner) rdata1_q <= mem_rdata;
        else       rdata0_q <= mem_rdata;
      end
    end
  end

`ifndef MEM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last <= 1'b1;
    else if (grant) last <= gsel;
  end
`endif

  assign busy     = (state != IDLE);
  assign ack_w    = (state == WAIT);
  assign m0_ack   = ack_w && !owner;
  assign m1_ack   = ack_w && owner;
  assign m0_rdata = (m0_ack && !cur_wr) ? mem_rdata : rdata0_q;
  assign m1_rdata = (m1_ack && !cur_wr) ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a synchronous-read memory model
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        m0_req, m0_wr, m0_byt, m0_ack;
  logic [15:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_wr, m1_byt, m1_ack;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, mem_byt;
  logic        owner, busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(.AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wr(m0_wr), .m0_byt(m0_byt),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wr(m1_wr), .m1_byt(m1_byt),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_byt(mem_byt),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: read data registered one cycle after the address; byte writes touch the low byte.
  logic [15:0] mem_model [0:65535];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      mem_model[16'h0300] <= 16'h80A5;
      mem_model[16'h0302] <= 16'h1234;
      mem_model[16'h0004] <= 16'h5A11;
      mem_model[16'h0010] <= 16'h1111;
      mem_init <= 1'b1;
    end else if (mem_wr) begin
      if (mem_byt) mem_model[mem_addr][7:0] <= mem_wdata[7:0];
      else         mem_model[mem_addr]      <= mem_wdata;
    end
    mem_rdata <= mem_model[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 1'b0; m0_wr = 1'b0; m0_byt = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_wr = 1'b0; m1_byt = 1'b0; m1_addr = '0; m1_wdata = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  int acks;
  bit found;

  initial begin
    do_reset();
    rst = 1'b1;
    step();
    check_eq("rst_busy",     32'(busy),     32'h0);
    check_eq("rst_owner",    32'(owner),    32'h0);
    check_eq("rst_mem_wr",   32'(mem_wr),   32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_m0_ack",   32'(m0_ack),   32'h0);
    check_eq("rst_m1_ack",   32'(m1_ack),   32'h0);
    check_eq("rst_m0_rdata", 32'(m0_rdata), 32'h0);
    check_eq("rst_m1_rdata", 32'(m1_rdata), 32'h0);
    rst = 1'b0;
    step();

    // Isolated m0 read of 0x0300
    m0_req = 1'b1; m0_addr = 16'h0300; m0_wr = 1'b0;
    step();
    check_eq("rd_issue_addr", 32'(mem_addr), 32'h0300);
    check_eq("rd_issue_busy", 32'(busy),     32'h1);
    check_eq("rd_issue_ack",  32'(m0_ack),   32'h0);
    step();
    check_eq("rd_ack",        32'(m0_ack),   32'h1);
    check_eq("rd_data",       32'(m0_rdata), 32'h80A5);
    check_eq("rd_m1_ack",     32'(m1_ack),   32'h0);
    m0_req = 1'b0;
    step();
    check_eq("rd_ack_pulse",  32'(m0_ack),   32'h0);
    check_eq("rd_idle_busy",  32'(busy),     32'h0);
    step();
    step();
    check_eq("rd_data_held",  32'(m0_rdata), 32'h80A5);

    // Address changed during ISSUE is ignored
    m0_req = 1'b1; m0_addr = 16'h0300;
    step();
    m0_addr = 16'h0302;
    step();
    check_eq("hold_addr",     32'(mem_addr), 32'h0300);
    check_eq("hold_ack",      32'(m0_ack),   32'h1);
    check_eq("hold_data",     32'(m0_rdata), 32'h80A5);
    m0_req = 1'b0;
    step();

    // m1 read, byte write, readback at 0x0004
    m1_req = 1'b1; m1_addr = 16'h0004; m1_wr = 1'b0;
    step();
    check_eq("m1rd_owner",    32'(owner),    32'h1);
    step();
    check_eq("m1rd_data",     32'(m1_rdata), 32'h5A11);
    m1_req = 1'b0;
    step();
    m1_req = 1'b1; m1_wr = 1'b1; m1_byt = 1'b1; m1_wdata = 16'h00DF;
    step();
    check_eq("bw_mem_wr",     32'(mem_wr),    32'h1);
    check_eq("bw_mem_addr",   32'(mem_addr),  32'h0004);
    check_eq("bw_mem_wdata",  32'(mem_wdata), 32'h00DF);
    check_eq("bw_mem_byt",    32'(mem_byt),   32'h1);
    check_eq("bw_no_ack",     32'(m1_ack),    32'h0);
    step();
    check_eq("bw_wr_low",     32'(mem_wr),    32'h0);
    check_eq("bw_ack",        32'(m1_ack),    32'h1);
    check_eq("bw_rdata_keep", 32'(m1_rdata),  32'h5A11);
    m1_req = 1'b0; m1_wr = 1'b0; m1_byt = 1'b0;
    step();
    check_eq("bw_rdata_held", 32'(m1_rdata),  32'h5A11);
    m1_req = 1'b1;
    step();
    step();
    check_eq("bw_readback",   32'(m1_rdata),  32'h5ADF);
    m1_req = 1'b0;
    step();

    // Reset asserted in the ISSUE cycle of an m0 write
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 16'h0010; m0_wdata = 16'hBEEF;
    step();
    check_eq("rw_issue_wr",   32'(mem_wr),   32'h1);
    #1;
    rst = 1'b1; m0_req = 1'b0; m0_wr = 1'b0;
    #1;
    check_eq("rw_wr_forced",  32'(mem_wr),   32'h0);
    check_eq("rw_busy",       32'(busy),     32'h0);
    check_eq("rw_rdata_clr",  32'(m0_rdata), 32'h0);
    step();
    check_eq("rw_no_ack",     32'(m0_ack),   32'h0);
    rst = 1'b0;
    step();
    m0_req = 1'b1;
    step();
    step();
    check_eq("rw_rb_ack",     32'(m0_ack),   32'h1);
    check_eq("rw_rb_data",    32'(m0_rdata), 32'h1111);
    m0_req = 1'b0;
    step();

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: m1 starves while m0 keeps requesting
    do_reset();
    m0_req = 1'b1; m0_addr = 16'h0300; m0_wr = 1'b0;
    m1_req = 1'b1; m1_addr = 16'h0004; m1_wr = 1'b0;
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m0_ack) acks++;
      check_eq("fp_m1_starved", 32'(m1_ack), 32'h0);
    end
    check_eq("fp_m0_acks", 32'(acks), 32'd4);
    m0_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (m1_ack && !found) begin
        found = 1'b1;
        check_eq("fp_m1_data", 32'(m1_rdata), 32'h5ADF);
      end
    end
    check_eq("fp_m1_acked", 32'(found), 32'h1);
    m1_req = 1'b0;
    step();
`else
    // Round robin: simultaneous requests after reset, m0 first, then alternating
    do_reset();
    m0_req = 1'b1; m0_addr = 16'h0300; m0_wr = 1'b0;
    m1_req = 1'b1; m1_addr = 16'h0004; m1_wr = 1'b0;
    step();
    check_eq("rr_t1_owner",  32'(owner),   32'h0);
    step();
    check_eq("rr_t2_m0ack",  32'(m0_ack),  32'h1);
    check_eq("rr_t2_m1ack",  32'(m1_ack),  32'h0);
    step();
    check_eq("rr_t3_owner",  32'(owner),   32'h1);
    check_eq("rr_t3_addr",   32'(mem_addr), 32'h0004);
    check_eq("rr_t3_noack",  32'({m0_ack, m1_ack}), 32'h0);
    step();
    check_eq("rr_t4_m1ack",  32'(m1_ack),  32'h1);
    check_eq("rr_t4_data",   32'(m1_rdata), 32'h5ADF);
    step();
    check_eq("rr_t5_noack",  32'({m0_ack, m1_ack}), 32'h0);
    step();
    check_eq("rr_t6_m0ack",  32'(m0_ack),  32'h1);
    step();
    step();
    check_eq("rr_t8_m1ack",  32'(m1_ack),  32'h1);
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    check_eq("rr_t9_idle",   32'(busy),    32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
